// File: rtl/nx_msg_encoder_pkg.sv
// Shared mesh message definitions: command codes, field positions and payload helpers.
// Kept identical on the decoder side so encode and decode agree bit-for-bit.
package nx_msg_encoder_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_INSTR = 2'd0,
    CMD_MAP_OUTPUT = 2'd1,
    CMD_SIG_STATE  = 2'd2,
    CMD_RESERVED   = 2'd3
  } nx_cmd_e;

  localparam int MSG_WIDTH       = 32;
  localparam int MSG_ROW_W       = 4;
  localparam int MSG_COL_W       = 4;
  localparam int MSG_CMD_W       = 2;
  localparam int MSG_PAYLOAD_W   = 22;
  localparam int MSG_ROW_LSB     = 28;
  localparam int MSG_COL_LSB     = 24;
  localparam int MSG_CMD_LSB     = 22;
  localparam int MSG_PAYLOAD_LSB = 0;
  localparam int LOAD_INSTR_W    = 15;
  localparam int LOAD_CORE_BIT   = 15;

  function automatic logic [MSG_WIDTH-1:0] pack_msg(
    input logic [MSG_ROW_W-1:0]     row,
    input logic [MSG_COL_W-1:0]     col,
    input logic [MSG_CMD_W-1:0]     cmd,
    input logic [MSG_PAYLOAD_W-1:0] payload
  );
    logic [MSG_WIDTH-1:0] msg;
    msg = '0;
    msg[MSG_ROW_LSB +: MSG_ROW_W]         = row;
    msg[MSG_COL_LSB +: MSG_COL_W]         = col;
    msg[MSG_CMD_LSB +: MSG_CMD_W]         = cmd;
    msg[MSG_PAYLOAD_LSB +: MSG_PAYLOAD_W] = payload;
    return msg;
  endfunction

  // Upper payload bits above the core flag are always zero for instruction loads.
  function automatic logic [MSG_PAYLOAD_W-1:0] load_payload(
    input logic                    core,
    input logic [LOAD_INSTR_W-1:0] instr
  );
    logic [MSG_PAYLOAD_W-1:0] p;
    p = '0;
    p[LOAD_CORE_BIT]       = core;
    p[LOAD_INSTR_W-1:0]    = instr;
    return p;
  endfunction

endpackage

// File: rtl/nx_msg_encoder_fifo.sv
// Two-entry registered FIFO for outbound mesh messages.
// Full/empty are registered so upstream ready never depends on the same-cycle pop.
module nx_msg_encoder_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_next;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_next = cnt_q;
    if (do_push && !do_pop) begin
      cnt_next = cnt_q + 2'd1;
    end else if (do_pop && !do_push) begin
      cnt_next = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q   <= cnt_next;
      full_q  <= (cnt_next == 2'd2);
      empty_q <= (cnt_next == 2'd0);
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nx_msg_encoder.sv
// Host-side mesh message encoder: single commands and instruction-load bursts
// are formatted into mesh messages and buffered toward the entry node.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | accepting single requests; a nonzero load start opens a burst
// ST_LOAD | burst in progress; instructions accepted until count reached
module nx_msg_encoder
  import nx_msg_encoder_pkg::*;
#(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 2,
  parameter int INSTR_WIDTH    = 15,
  parameter int MAX_INSTRS     = 512,
  parameter int PAYLOAD_WIDTH  = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_ROW_WIDTH-1:0]     req_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]     req_col_i,
  input  logic [COMMAND_WIDTH-1:0]      req_cmd_i,
  input  logic [PAYLOAD_WIDTH-1:0]      req_payload_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_ROW_WIDTH-1:0]     load_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]     load_col_i,
  input  logic                          load_core_i,
  input  logic [$clog2(MAX_INSTRS):0]   load_count_i,
  input  logic                          load_start_i,
  output logic                          load_busy_o,
  input  logic [INSTR_WIDTH-1:0]        instr_data_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  output logic [STREAM_WIDTH-1:0]       msg_data_o,
  output logic                          msg_valid_o,
  input  logic                          msg_ready_i,
  output logic                          idle_o
);

  localparam int CNT_W = $clog2(MAX_INSTRS) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e                    state_q;
  logic [ADDR_ROW_WIDTH-1:0] row_q;
  logic [ADDR_COL_WIDTH-1:0] col_q;
  logic                      core_q;
  logic [CNT_W-1:0]          count_q;
  logic [CNT_W-1:0]          sent_q;

  logic                      load_go;
  logic                      req_fire;
  logic                      instr_fire;
  logic                      push;
  logic [STREAM_WIDTH-1:0]   push_data;
  logic                      fifo_full;
  logic                      fifo_empty;

  // A zero-length load start is treated as absent, so it neither opens a burst nor blocks requests.
  assign load_go       = load_start_i && (load_count_i != '0);
  assign req_ready_o   = (state_q == ST_IDLE) && !load_go && !fifo_full;
  assign instr_ready_o = (state_q == ST_LOAD) && !fifo_full;
  assign req_fire      = req_valid_i && req_ready_o;
  assign instr_fire    = instr_valid_i && instr_ready_o;
  assign push          = req_fire || instr_fire;

  always_comb begin
    push_data = pack_msg(req_row_i, req_col_i, req_cmd_i, req_payload_i);
    if (instr_fire) begin
      push_data = pack_msg(row_q, col_q, CMD_LOAD_INSTR, load_payload(core_q, instr_data_i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      core_q  <= 1'b0;
      count_q <= '0;
      sent_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_go) begin
            state_q <= ST_LOAD;
            row_q   <= load_row_i;
            col_q   <= load_col_i;
            core_q  <= load_core_i;
            count_q <= load_count_i;
            sent_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (instr_fire) begin
            if (sent_q == count_q - 1'b1) begin
              state_q <= ST_IDLE;
            end else begin
              sent_q <= sent_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  nx_msg_encoder_fifo #(
    .WIDTH(STREAM_WIDTH)
  ) u_out_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (msg_valid_o && msg_ready_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (msg_data_o)
  );

  assign msg_valid_o = !fifo_empty;
  assign load_busy_o = (state_q == ST_LOAD);
  assign idle_o      = (state_q == ST_IDLE) && fifo_empty && !req_valid_i;

endmodule

// File: tb/tb_nx_msg_encoder.sv
// Directed bench for nx_msg_encoder with an in-order scoreboard on the outbound stream.
module tb_nx_msg_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_row_i, req_col_i;
  logic [1:0]  req_cmd_i;
  logic [21:0] req_payload_i;
  logic        req_valid_i, req_ready_o;
  logic [3:0]  load_row_i, load_col_i;
  logic        load_core_i;
  logic [9:0]  load_count_i;
  logic        load_start_i, load_busy_o;
  logic [14:0] instr_data_i;
  logic        instr_valid_i, instr_ready_o;
  logic [31:0] msg_data_o;
  logic        msg_valid_o, msg_ready_i;
  logic        idle_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [31:0] sb_q [$];
  logic [14:0] instr_buf [$];
  logic [3:0]  b_row, b_col;
  logic        b_core;
  int busy_cycles, stall_cycles;

  always #5 clk_i = ~clk_i;

  nx_msg_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_row_i(req_row_i), .req_col_i(req_col_i), .req_cmd_i(req_cmd_i),
    .req_payload_i(req_payload_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .load_row_i(load_row_i), .load_col_i(load_col_i), .load_core_i(load_core_i),
    .load_count_i(load_count_i), .load_start_i(load_start_i), .load_busy_o(load_busy_o),
    .instr_data_i(instr_data_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .msg_data_o(msg_data_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .idle_o(idle_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected words are built from the driven stimulus at each input handshake.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (msg_valid_o) begin
        if (sb_q.size() == 0) begin
          check("msg_unexpected", msg_data_o, 32'hxxxx_xxxx);
        end else begin
          check("msg_data", msg_data_o, sb_q[0]);
          if (msg_ready_i) begin
            void'(sb_q.pop_front());
            n_pop++;
          end
        end
      end
      if (req_valid_i && req_ready_o)
        sb_q.push_back({req_row_i, req_col_i, req_cmd_i, req_payload_i});
      if (instr_valid_i && instr_ready_o)
        sb_q.push_back({b_row, b_col, 2'b00, 6'b000000, b_core, instr_data_i});
    end
  end

  task automatic start_load(input logic [3:0] r, input logic [3:0] c, input logic core,
                            input logic [9:0] cnt);
    load_row_i = r; load_col_i = c; load_core_i = core; load_count_i = cnt;
    b_row = r; b_col = c; b_core = core;
    load_start_i = 1'b1;
    @(posedge clk_i); #1;
    load_start_i = 1'b0;
  endtask

  task automatic send_instrs(input int n);
    int idx = 0;
    int budget = 0;
    logic acc;
    busy_cycles = 0;
    stall_cycles = 0;
    while (idx < n && budget < 2000) begin
      instr_valid_i = 1'b1;
      instr_data_i  = instr_buf[idx];
      @(negedge clk_i);
      acc = instr_ready_o;
      if (load_busy_o) busy_cycles++;
      if (!acc) stall_cycles++;
      @(posedge clk_i); #1;
      if (acc) idx++;
      budget++;
    end
    instr_valid_i = 1'b0;
    check("instr_accept_count", idx, n);
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] c, input logic [1:0] cmd,
                         input logic [21:0] p);
    req_row_i = r; req_col_i = c; req_cmd_i = cmd; req_payload_i = p;
    req_valid_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, idx, budget, pop0;
    logic acc;
    logic [21:0] bp_pay [4];

    rst_i = 1'b0;
    req_row_i = '0; req_col_i = '0; req_cmd_i = '0; req_payload_i = '0; req_valid_i = 1'b0;
    load_row_i = '0; load_col_i = '0; load_core_i = 1'b0; load_count_i = '0; load_start_i = 1'b0;
    instr_data_i = '0; instr_valid_i = 1'b0; msg_ready_i = 1'b1;
    b_row = '0; b_col = '0; b_core = 1'b0;

    // Reset values
    #12;
    check("rst_msg_valid", msg_valid_o, 0);
    check("rst_msg_data", msg_data_o, 32'h0);
    check("rst_load_busy", load_busy_o, 0);
    check("rst_instr_ready", instr_ready_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_idle", idle_o, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Single request, one-cycle latency
    set_req(4'd2, 4'd3, 2'd2, 22'h000015);
    @(negedge clk_i);
    check("single_req_ready", req_ready_o, 1);
    check("single_no_comb_path", msg_valid_o, 0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("single_valid_n1", msg_valid_o, 1);
    check("single_data", msg_data_o, 32'h2380_0015);
    check("single_ready_stays", req_ready_o, 1);
    @(posedge clk_i); #1;

    // Three-instruction burst
    start_load(4'd1, 4'd0, 1'b1, 10'd3);
    instr_buf.delete();
    instr_buf.push_back(15'h0001);
    instr_buf.push_back(15'h7FFF);
    instr_buf.push_back(15'h1234);
    send_instrs(3);
    check("burst_busy_cycles", busy_cycles, 3);
    @(negedge clk_i);
    check("burst_busy_done", load_busy_o, 0);
    check("burst_msg3", msg_data_o, 32'h1000_9234);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("burst_sb_empty", sb_q.size(), 0);

    // Backpressure: 4 requests against a stalled sink
    for (int k = 0; k < 4; k++) bp_pay[k] = 22'h000100 + 22'(k);
    msg_ready_i = 1'b0;
    accepted = 0; idx = 0;
    pop0 = n_pop;
    for (int cyc = 0; cyc < 5; cyc++) begin
      set_req(4'd4, 4'd5, 2'd1, bp_pay[idx]);
      @(negedge clk_i);
      acc = req_ready_o;
      if (acc) accepted++;
      @(posedge clk_i); #1;
      if (acc) idx++;
    end
    check("bp_accepted", accepted, 2);
    @(negedge clk_i);
    check("bp_ready_low", req_ready_o, 0);
    check("bp_valid_held", msg_valid_o, 1);
    @(posedge clk_i); #1;
    msg_ready_i = 1'b1;
    budget = 0;
    while (idx < 4 && budget < 50) begin
      set_req(4'd4, 4'd5, 2'd1, bp_pay[idx]);
      @(negedge clk_i);
      acc = req_ready_o;
      @(posedge clk_i); #1;
      if (acc) idx++;
      budget++;
    end
    req_valid_i = 1'b0;
    check("bp_all_accepted", idx, 4);
    repeat (4) @(posedge clk_i);
    #1;
    check("bp_pop_count", n_pop - pop0, 4);
    check("bp_sb_empty", sb_q.size(), 0);

    // Load start beats a simultaneous request
    load_row_i = 4'd6; load_col_i = 4'd7; load_core_i = 1'b0; load_count_i = 10'd2;
    b_row = 4'd6; b_col = 4'd7; b_core = 1'b0;
    load_start_i = 1'b1;
    set_req(4'd9, 4'd8, 2'd3, 22'h3ABCDE);
    @(negedge clk_i);
    check("prio_req_blocked", req_ready_o, 0);
    @(posedge clk_i); #1;
    load_start_i = 1'b0;
    @(negedge clk_i);
    check("prio_busy", load_busy_o, 1);
    @(posedge clk_i); #1;
    instr_buf.delete();
    instr_buf.push_back(15'h0AAA);
    instr_buf.push_back(15'h5555);
    send_instrs(2);
    acc = 1'b0; budget = 0;
    while (!acc && budget < 10) begin
      @(negedge clk_i);
      acc = req_ready_o;
      if (acc) check("prio_req_after_burst", load_busy_o, 0);
      @(posedge clk_i); #1;
      budget++;
    end
    req_valid_i = 1'b0;
    check("prio_req_taken", acc, 1);

    // Zero-count load is ignored; request goes through the same cycle
    load_count_i = 10'd0; load_start_i = 1'b1;
    set_req(4'd0, 4'd1, 2'd0, 22'h012345);
    @(negedge clk_i);
    check("zero_req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;
    load_start_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i);
    check("zero_no_busy", load_busy_o, 0);
    @(posedge clk_i); #1;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset in the middle of a 5-instruction burst
    start_load(4'd3, 4'd2, 1'b0, 10'd5);
    instr_buf.delete();
    for (int k = 0; k < 5; k++) instr_buf.push_back(15'h0100 + 15'(k));
    send_instrs(2);
    instr_valid_i = 1'b1;
    #1;
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", msg_valid_o, 0);
    check("mid_rst_data", msg_data_o, 32'h0);
    check("mid_rst_busy", load_busy_o, 0);
    check("mid_rst_instr_ready", instr_ready_o, 0);
    check("mid_rst_req_ready", req_ready_o, 1);
    check("mid_rst_idle", idle_o, 1);
    instr_valid_i = 1'b0;
    sb_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    start_load(4'd3, 4'd2, 1'b1, 10'd1);
    instr_buf.delete();
    instr_buf.push_back(15'h2468);
    send_instrs(1);
    @(negedge clk_i);
    check("restart_done", load_busy_o, 0);
    check("restart_msg", msg_data_o, 32'h3200_A468);
    @(posedge clk_i); #1;

    // Full-length 512 instruction burst at full throughput
    instr_buf.delete();
    for (int k = 0; k < 512; k++) instr_buf.push_back(15'((k * 37) & 16'h7FFF));
    pop0 = n_pop;
    start_load(4'd15, 4'd15, 1'b0, 10'd512);
    send_instrs(512);
    check("long_no_stall", stall_cycles, 0);
    check("long_busy_cycles", busy_cycles, 512);
    @(negedge clk_i);
    check("long_not_idle_yet", idle_o, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("long_idle_after_pop", idle_o, 1);
    check("long_pop_count", n_pop - pop0, 512);
    check("long_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
